fetch_pcreg: RTL and testbench
==============================

// Module: fetch_pcreg
// PURPOSE
//  PC register and instruction-bus front end of the fetch stage. It sits directly downstream of the
//  next-PC mux. It returns pc+4 to that mux and registers the selected next PC every cycle. It runs
//  one outstanding ibus read per PC and delivers {valid, pc, instr} to the fetch->decode register.
//  It raises stallI while a fetch is in flight.
// PARAMETERS
//  PCINIT  64'h8000_0000  PC value loaded at reset
// PORTS
//  clk           in   1    clock, all state updates on posedge
//  reset         in   1    asynchronous, active-low (reset==0 clears state immediately)
//  pc_selected   in   64   next PC from the next-PC mux
//  jump          in   1    redirect: current fetch is stale; bubble into decode
//  stall_down    in   1    decode/later stage cannot accept (stall|stallM combined)
//  pcplus4       out  64   pc + 4, fed back to the next-PC mux
//  stallI        out  1    fetch not complete this cycle
//  ireq          out  ibus_req_t   {valid, addr}
//  iresp         in   ibus_resp_t  {addr_ok, data_ok, data[31:0]}
//  dreg_valid    out  1    fetch->decode register valid
//  dreg_pc       out  64   PC of instr in the decode register
//  dreg_instr    out  32   instruction word
// BEHAVIOUR
//  Reset values:
//   - pc=PCINIT, state=S_REQ, ireq.valid=0 during reset, ireq.addr=PCINIT.
//   - dreg_valid=0, dreg_pc=0, dreg_instr=0.
//   - A reset mid-transaction abandons it; no bus handshake is owed.
//  PC register:
//   - pc <= pc_selected every cycle. The mux already holds the PC under stallI/stall.
//   - pcplus4 = pc + 64'd4, modulo 2^64 (wraps silently).
//  ibus rule:
//   - Once ireq.valid=1, ireq.addr and valid stay stable until the cycle iresp.data_ok=1.
//   - ireq.addr is a separate register (areg), so a jump can move pc without disturbing the bus.
//  FSM:
//   - S_REQ:
//     - Drive valid=1, addr=areg.
//     - data_ok & !jump & !stall_down: capture instr into dreg; areg<=pc_selected; stay in S_REQ.
//     - data_ok & !jump & stall_down: latch instr into a hold buffer; go to S_HOLD.
//     - data_ok & jump: drop the data; areg<=pc_selected; stay in S_REQ.
//     - !data_ok & jump: go to S_DRAIN.
//   - S_HOLD:
//     - valid=0, instr held.
//     - When !stall_down: load dreg from the buffer; areg<=pc_selected; go to S_REQ.
//     - jump in S_HOLD: drop the buffer; areg<=pc_selected; go to S_REQ.
//   - S_DRAIN:
//     - Keep the stale request valid.
//     - On data_ok: discard; areg<=pc (the redirect target); go to S_REQ.
//     - A further jump here updates pc only.
//  stallI:
//   - 1 in S_REQ/S_DRAIN unless (S_REQ & data_ok & !jump).
//   - 0 in S_HOLD; the hold is signalled by stall_down.
//  Fetch->decode register:
//   - jump: dreg_valid<=0 (bubble), regardless of other inputs.
//   - stall_down & !jump: dreg holds.
//   - Else: dreg_valid<=fetch_done; pc and instr load with it.
//  Latency:
//   - data_ok in cycle N makes dreg valid at N+1.
//   - Back-to-back hits give one instr/cycle when data_ok is combinational.
//  Misaligned addr (addr[1:0]!=0) is issued unchanged; the exception is handled downstream.
// STRUCTURE
//  - Package common (shared): u64/u32/u1, ibus_req_t, ibus_resp_t, PCINIT_DEFAULT.
//  - Package pipes (shared): fetch_data_t {valid, pc, instr}, state enum fetch_state_t.
//  - Natural sub-module: fetch_dreg (fetch->decode register with flush/stall priority).
// TESTING
//  1. Release reset, ibus answers data_ok same cycle with 32'h00000013 ->
//     addrs 8000_0000, _0004, _0008 on consecutive cycles; dreg_valid=1 from the 2nd cycle.
//  2. data_ok delayed 3 cycles -> stallI=1 for 3 cycles, ireq.addr stable, pc unchanged, dreg_valid=0.
//  3. jump to 8000_0100 while a request is in flight with data_ok 2 cycles later -> stale data dropped;
//     next ireq.addr=8000_0100; dreg_valid=0 until that data returns.
//  4. stall_down=1 for 4 cycles at data_ok -> S_HOLD, ireq.valid=0, dreg unchanged;
//     on release dreg gets the held instr, then the fetch of pc+4 issues.
//  5. reset driven low mid-S_DRAIN -> immediately pc=8000_0000, ireq.valid=0, dreg_valid=0.
//  6. pc=FFFF_FFFF_FFFF_FFFC -> pcplus4=0, no X propagation.

Source files
------------

// File: rtl/fetch_pcreg_pkg.sv
// Shared types for the fetch PC register / instruction-bus front end.
//   u64/u32/u1       : scalar aliases
//   ibus_req_t       : {valid, addr} request to the instruction bus
//   ibus_resp_t      : {addr_ok, data_ok, data} response from the instruction bus
//   fetch_data_t     : {valid, pc, instr} payload of the fetch->decode register
//   fetch_state_t    : fetch FSM states
package fetch_pcreg_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] u64;
  typedef logic [ILEN-1:0] u32;
  typedef logic            u1;

  localparam u64 PCINIT_DEFAULT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    u1  valid;
    u64 addr;
  } ibus_req_t;

  typedef struct packed {
    u1  addr_ok;
    u1  data_ok;
    u32 data;
  } ibus_resp_t;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  // Sequential PC; wraps modulo 2^64.
  function automatic u64 pc_inc4(input u64 pc);
    return pc + u64'(4);
  endfunction

endpackage

// File: rtl/fetch_pcreg_dreg.sv
// Fetch->decode pipeline register.
//   clk, rst_n_i : clock, async active-low reset
//   flush_i      : insert a bubble (wins over everything)
//   stall_i      : downstream cannot accept; hold contents
//   fetch_i      : completed fetch this cycle (valid qualifies pc/instr)
//   dreg_o       : registered {valid, pc, instr}
module fetch_pcreg_dreg
  import fetch_pcreg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  fetch_data_t fetch_i,
  output fetch_data_t dreg_o
);

  fetch_data_t dreg_q, dreg_d;

  // Priority: flush > stall > load.
  always_comb begin
    dreg_d = dreg_q;
    if (flush_i) begin
      dreg_d.valid = 1'b0;
    end else if (!stall_i) begin
      dreg_d.valid = fetch_i.valid;
      if (fetch_i.valid) begin
        dreg_d.pc    = fetch_i.pc;
        dreg_d.instr = fetch_i.instr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) dreg_q <= '0;
    else          dreg_q <= dreg_d;
  end

  assign dreg_o = dreg_q;

endmodule

// File: rtl/fetch_pcreg.sv
// Fetch-stage PC register and instruction-bus front end.
//   clk, reset   : clock, async active-low reset
//   pc_selected  : next PC from the next-PC mux (registered every cycle)
//   jump         : redirect; in-flight fetch is stale, bubble into decode
//   stall_down   : decode or later stage cannot accept
//   pcplus4      : pc + 4 back to the next-PC mux
//   stallI       : fetch not complete this cycle
//   ireq / iresp : instruction bus request / response
//   dreg_*       : fetch->decode register contents
module fetch_pcreg
  import fetch_pcreg_pkg::*;
#(
  parameter u64 PCINIT = PCINIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  u64         pc_selected,
  input  logic       jump,
  input  logic       stall_down,
  output u64         pcplus4,
  output logic       stallI,
  output ibus_req_t  ireq,
  input  ibus_resp_t iresp,
  output logic       dreg_valid,
  output u64         dreg_pc,
  output u32         dreg_instr
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           areg_q, areg_d;
  u32           hold_q, hold_d;

  fetch_data_t  fetch_c;
  fetch_data_t  dreg_c;
  logic         req_valid_c;
  logic         stall_c;
  logic         unused_addr_ok;

  assign unused_addr_ok = iresp.addr_ok;

  // Next-state, bus request and fetch completion.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_selected;
    areg_d        = areg_q;
    hold_d        = hold_q;
    req_valid_c   = 1'b0;
    stall_c       = 1'b0;
    fetch_c.valid = 1'b0;
    fetch_c.pc    = areg_q;
    fetch_c.instr = iresp.data;

    case (state_q)
      S_REQ: begin
        req_valid_c = 1'b1;
        stall_c     = !(iresp.data_ok && !jump);
        if (iresp.data_ok) begin
          if (jump) begin
            areg_d = pc_selected;
          end else if (stall_down) begin
            hold_d  = iresp.data;
            state_d = S_HOLD;
          end else begin
            fetch_c.valid = 1'b1;
            areg_d        = pc_selected;
          end
        end else if (jump) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        // A jump here also flushes dreg, so the buffered word is simply dropped.
        fetch_c.instr = hold_q;
        fetch_c.valid = !stall_down;
        if (jump || !stall_down) begin
          areg_d  = pc_selected;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // Stale request must complete; pc already holds the redirect target.
        req_valid_c = 1'b1;
        stall_c     = 1'b1;
        if (iresp.data_ok) begin
          areg_d  = pc_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= PCINIT;
      areg_q  <= PCINIT;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      areg_q  <= areg_d;
      hold_q  <= hold_d;
    end
  end

  fetch_pcreg_dreg u_dreg (
    .clk     (clk),
    .rst_n_i (reset),
    .flush_i (jump),
    .stall_i (stall_down),
    .fetch_i (fetch_c),
    .dreg_o  (dreg_c)
  );

  // Request is suppressed while reset is asserted.
  assign ireq.valid = req_valid_c & reset;
  assign ireq.addr  = areg_q;
  assign stallI     = stall_c;
  assign pcplus4    = pc_inc4(pc_q);
  assign dreg_valid = dreg_c.valid;
  assign dreg_pc    = dreg_c.pc;
  assign dreg_instr = dreg_c.instr;

endmodule

// File: tb/tb_fetch_pcreg.sv
// Directed bench for fetch_pcreg with a scoreboard of delivered fetches.
module tb_fetch_pcreg;
  import fetch_pcreg_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  u64         pc_selected;
  logic       jump;
  logic       stall_down;
  u64         pcplus4;
  logic       stallI;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       dreg_valid;
  u64         dreg_pc;
  u32         dreg_instr;

  int total = 0;
  int bad   = 0;

  u64          m_pc;
  fetch_data_t sb_q[$];
  fetch_data_t last_d;

  always #5 clk = ~clk;

  fetch_pcreg dut (
    .clk         (clk),
    .reset       (reset),
    .pc_selected (pc_selected),
    .jump        (jump),
    .stall_down  (stall_down),
    .pcplus4     (pcplus4),
    .stallI      (stallI),
    .ireq        (ireq),
    .iresp       (iresp),
    .dreg_valid  (dreg_valid),
    .dreg_pc     (dreg_pc),
    .dreg_instr  (dreg_instr)
  );

  task automatic chk(input string tag, input u64 obs, input u64 exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check bus/stall before posedge, check dreg after it.
  task automatic step(input string tag, input bit dok, input u32 rdata, input bit jmp,
                      input u64 tgt, input bit sd, input bit e_stalli, input bit e_valid,
                      input u64 e_addr, input bit e_push, input bit e_dv);
    u64 sel;
    @(negedge clk);
    iresp.addr_ok = 1'b1;
    iresp.data_ok = dok;
    iresp.data    = rdata;
    jump          = jmp;
    stall_down    = sd;
    sel = jmp ? tgt : ((e_stalli || sd) ? m_pc : m_pc + 64'd4);
    pc_selected = sel;
    if (e_push) sb_q.push_back('{valid: 1'b1, pc: e_addr, instr: rdata});
    #1;
    chk({tag, ".stallI"}, 64'(stallI), 64'(e_stalli));
    chk({tag, ".ivalid"}, 64'(ireq.valid), 64'(e_valid));
    if (e_valid) chk({tag, ".iaddr"}, ireq.addr, e_addr);
    chk({tag, ".pcplus4"}, pcplus4, m_pc + 64'd4);
    @(posedge clk);
    m_pc = sel;
    #1;
    chk({tag, ".dvalid"}, 64'(dreg_valid), 64'(e_dv));
    if (e_dv) begin
      if (!sd && !jmp) begin
        chk({tag, ".sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) last_d = sb_q.pop_front();
      end
      chk({tag, ".dpc"}, dreg_pc, last_d.pc);
      chk({tag, ".dinstr"}, 64'(dreg_instr), 64'(last_d.instr));
    end
  endtask

  localparam u64 P0 = 64'h0000_0000_8000_0000;

  initial begin
    reset       = 1'b1;
    jump        = 1'b0;
    stall_down  = 1'b0;
    iresp       = '0;
    pc_selected = P0;
    m_pc        = P0;
    last_d      = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst.ivalid", 64'(ireq.valid), 64'd0);
    chk("rst.iaddr", ireq.addr, P0);
    chk("rst.pcplus4", pcplus4, P0 + 64'd4);
    chk("rst.dvalid", 64'(dreg_valid), 64'd0);
    chk("rst.dpc", dreg_pc, 64'd0);
    chk("rst.dinstr", 64'(dreg_instr), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: same-cycle data_ok, back-to-back fetches
    step("t1a", 1, 32'h0000_0013, 0, 0, 0, 0, 1, P0,         1, 1);
    step("t1b", 1, 32'h0000_0013, 0, 0, 0, 0, 1, P0 + 64'h4, 1, 1);
    step("t1c", 1, 32'h0000_0013, 0, 0, 0, 0, 1, P0 + 64'h8, 1, 1);
    // 2: data_ok three cycles late
    step("t2a", 0, 32'h0,         0, 0, 0, 1, 1, P0 + 64'hC, 0, 0);
    step("t2b", 0, 32'h0,         0, 0, 0, 1, 1, P0 + 64'hC, 0, 0);
    step("t2c", 0, 32'h0,         0, 0, 0, 1, 1, P0 + 64'hC, 0, 0);
    step("t2d", 1, 32'h1111_0001, 0, 0, 0, 0, 1, P0 + 64'hC, 1, 1);
    // 3: jump while a fetch is in flight; stale data dropped
    step("t3a", 0, 32'h0,         1, P0 + 64'h100, 0, 1, 1, P0 + 64'h10, 0, 0);
    step("t3b", 0, 32'h0,         0, 0, 0, 1, 1, P0 + 64'h10, 0, 0);
    step("t3c", 1, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, P0 + 64'h10, 0, 0);
    step("t3d", 1, 32'h2222_0002, 0, 0, 0, 0, 1, P0 + 64'h100, 1, 1);
    // 4: stall_down for four cycles at data_ok, then release
    step("t4a", 1, 32'h3333_0003, 0, 0, 1, 0, 1, P0 + 64'h104, 1, 1);
    step("t4b", 0, 32'h0,         0, 0, 1, 0, 0, 0, 0, 1);
    step("t4c", 0, 32'h0,         0, 0, 1, 0, 0, 0, 0, 1);
    step("t4d", 0, 32'h0,         0, 0, 1, 0, 0, 0, 0, 1);
    step("t4e", 0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 1);
    step("t4f", 1, 32'h4444_0004, 0, 0, 0, 0, 1, P0 + 64'h108, 1, 1);
    // 6: wrap of pcplus4 at top of address space, then misaligned issue
    step("t6a", 1, 32'h5555_0005, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, P0 + 64'h10C, 0, 0);
    step("t6b", 1, 32'h6666_0006, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    step("t6c", 1, 32'h7777_0007, 0, 0, 0, 0, 1, 64'h0, 1, 1);
    step("t6d", 1, 32'h0,         1, 64'h102, 0, 1, 1, 64'h4, 0, 0);
    step("t6e", 1, 32'h8888_0008, 0, 0, 0, 0, 1, 64'h102, 1, 1);
    // 5: reset asserted while draining a stale request
    step("t5a", 0, 32'h0,         1, P0 + 64'h200, 0, 1, 1, 64'h106, 0, 0);
    step("t5b", 0, 32'h0,         0, 0, 0, 1, 1, 64'h106, 0, 0);
    #3 reset = 1'b0;
    #1;
    chk("t5.pcplus4", pcplus4, P0 + 64'd4);
    chk("t5.ivalid", 64'(ireq.valid), 64'd0);
    chk("t5.iaddr", ireq.addr, P0);
    chk("t5.dvalid", 64'(dreg_valid), 64'd0);
    m_pc        = P0;
    pc_selected = P0;
    @(posedge clk);
    #1 reset = 1'b1;
    step("t5c", 1, 32'h9999_0009, 0, 0, 0, 0, 1, P0, 1, 1);

    chk("sb.empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
